// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART constants and the transmit-side FSM state type.
// Latency/backpressure: none (declarations only).
package uart_pkg;

  localparam int UART_DATA_W   = 8;
  localparam int TICKS_PER_BIT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } tx_state_t;

  function automatic logic state_busy(input tx_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Host write port plus transmitter handshake, bundled for uart_tx_fifo.
// master = host/transmitter side, slave = the buffering block.
interface uart_tx_fifo_if #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) ();

  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  tx_start;
  logic [DATA_W-1:0]     tx_data;
  logic                  tx_done_tick;
  logic                  busy;
  logic                  ovf;
  logic                  ovf_clr;

  modport master (
    output wr_en, wr_data, tx_done_tick, ovf_clr,
    input  full, empty, level, tx_start, tx_data, busy, ovf
  );

  modport slave (
    input  wr_en, wr_data, tx_done_tick, ovf_clr,
    output full, empty, level, tx_start, tx_data, busy, ovf
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO: registered level/flags, combinational head read; 1-cycle push-to-visible.
// Push while full and pop while empty are ignored; full is judged before any same-cycle pop.
module uart_sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 push,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 pop,
  output logic [DATA_W-1:0]    rd_data,
  output logic [DEPTH_LOG2:0]  level,
  output logic                 full,
  output logic                 empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter one frame at a time; tx_start one edge after the pop edge.
// Host drops words when full (sticky ovf only with UART_TX_FIFO_OVF_EN); tx_data held through each frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = UART_DATA_W,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  uart_tx_fifo_if.slave     bus
);

  tx_state_t             state;
  tx_state_t             state_next;
  logic                  pop;
  logic [DATA_W-1:0]     fifo_rd_data;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [DATA_W-1:0]     tx_data_q;

  uart_sync_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (bus.wr_en),
    .wr_data (bus.wr_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .level   (fifo_level),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // tx_done_tick only matters in WAIT; it is dropped in IDLE and START.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty) state_next = ST_START;
      ST_START: state_next = ST_WAIT;
      ST_WAIT:  if (bus.tx_done_tick) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pop          = (state == ST_IDLE) && !fifo_empty;
    bus.tx_start = (state == ST_START);
    bus.busy     = state_busy(state);
  end

  // The transmitter samples data bits live, so this register only moves on the pop edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_data_q <= '0;
    end else if (pop) begin
      tx_data_q <= fifo_rd_data;
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.level   = fifo_level;
  assign bus.full    = fifo_full;
  assign bus.empty   = fifo_empty;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // A rejected push in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && fifo_full) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: vector table plus hand-written frame sequences.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DATA_W(8), .DEPTH_LOG2(4)) bus ();

  uart_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       done;
    logic [4:0] lvl;
    logic       emp;
    logic       start;
    logic       bsy;
    logic [7:0] dat;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.wr_en        = 1'b0;
    bus.wr_data      = 8'h00;
    bus.tx_done_tick = 1'b0;
    bus.ovf_clr      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (bus.tx_start !== 1'b1 && n < 50) begin
      step();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int n;
    logic [7:0] exp4 [4];

    // 1: reset then idle
    do_reset();
    chk("t1_empty", bus.empty, 1);
    chk("t1_level", bus.level, 0);
    chk("t1_busy", bus.busy, 0);
    chk("t1_tx_data", bus.tx_data, 0);
    chk("t1_ovf", bus.ovf, 0);
    bad = 0;
    repeat (10) begin
      step();
      if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.empty !== 1'b1) bad++;
    end
    chk("t1_idle_quiet", bad, 0);

    // Vector table: push aligned with an IDLE pop at level 1, done ignored in START
    vecs[0] = '{1'b1, 8'h3C, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 8'h5A, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1, 8'h3C};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'h3C};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h3C};
    vecs[4] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, 8'h5A};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 8'h5A};
    vecs[6] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 8'h5A};
    vecs[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[8] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 8'h5A};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.wr_en        = vecs[i].wr_en;
      bus.wr_data      = vecs[i].wr_data;
      bus.tx_done_tick = vecs[i].done;
      step();
      chk($sformatf("vec%0d_level", i), bus.level, vecs[i].lvl);
      chk($sformatf("vec%0d_empty", i), bus.empty, vecs[i].emp);
      chk($sformatf("vec%0d_tx_start", i), bus.tx_start, vecs[i].start);
      chk($sformatf("vec%0d_busy", i), bus.busy, vecs[i].bsy);
      chk($sformatf("vec%0d_tx_data", i), bus.tx_data, vecs[i].dat);
    end
    bus.wr_en = 1'b0;
    bus.tx_done_tick = 1'b0;

    // 2: single byte latency, long frame
    do_reset();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    step();
    bus.wr_en = 1'b0;
    chk("t2_level_n", bus.level, 1);
    chk("t2_data_n", bus.tx_data, 8'h00);
    chk("t2_start_n", bus.tx_start, 0);
    step();
    chk("t2_data_n1", bus.tx_data, 8'hA5);
    chk("t2_start_n1", bus.tx_start, 1);
    step();
    chk("t2_start_n2", bus.tx_start, 0);
    chk("t2_busy_n2", bus.busy, 1);
    bad = 0;
    repeat (159) begin
      step();
      if (bus.tx_start !== 1'b0 || bus.busy !== 1'b1 || bus.tx_data !== 8'hA5) bad++;
    end
    chk("t2_wait_hold", bad, 0);
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    chk("t2_busy_after_done", bus.busy, 0);
    chk("t2_empty_after_done", bus.empty, 1);

    // 3: fill while stalled, overflow, drain order
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(i);
      step();
    end
    bus.wr_en = 1'b0;
    chk("t3_level_full", bus.level, 16);
    chk("t3_full", bus.full, 1);
    chk("t3_first_popped", bus.tx_data, 8'h00);
    chk("t3_ovf_before", bus.ovf, 0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h11;
    step();
    bus.wr_en = 1'b0;
    chk("t3_level_drop", bus.level, 16);
    chk("t3_ovf_set", bus.ovf, OVF_EN);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h12;
    bus.ovf_clr = 1'b1;
    step();
    bus.wr_en = 1'b0;
    chk("t3_ovf_set_wins", bus.ovf, OVF_EN);
    step();
    bus.ovf_clr = 1'b0;
    chk("t3_ovf_cleared", bus.ovf, 0);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("t3_order%0d", i), bus.tx_data, 32'(i));
      bus.tx_done_tick = 1'b1;
      step();
      bus.tx_done_tick = 1'b0;
      if (i < 16) begin
        wait_start(n);
        chk($sformatf("t3_start%0d", i + 1), bus.tx_start, 1);
        step();
      end
    end
    chk("t3_drained_empty", bus.empty, 1);
    chk("t3_drained_busy", bus.busy, 0);

    // 4: stream of four frames, restart two cycles after each done
    exp4[0] = 8'h11; exp4[1] = 8'h22; exp4[2] = 8'h33; exp4[3] = 8'h44;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = exp4[i];
      step();
    end
    bus.wr_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t4_data%0d", k), bus.tx_data, exp4[k]);
      bad = 0;
      repeat (20) begin
        step();
        if (bus.tx_data !== exp4[k] || bus.tx_start !== 1'b0 || bus.busy !== 1'b1) bad++;
      end
      chk($sformatf("t4_stable%0d", k), bad, 0);
      bus.tx_done_tick = 1'b1;
      step();
      bus.tx_done_tick = 1'b0;
      chk($sformatf("t4_gap1_%0d", k), bus.tx_start, 0);
      step();
      chk($sformatf("t4_start_after_done%0d", k), bus.tx_start, (k < 3) ? 1 : 0);
      step();
    end
    chk("t4_end_busy", bus.busy, 0);

    // 6: reset mid-WAIT with five words queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'(8'hC0 + i);
      step();
    end
    bus.wr_en = 1'b0;
    step();
    chk("t6_level_pre", bus.level, 5);
    chk("t6_busy_pre", bus.busy, 1);
    #3 reset_n = 1'b0;
    #1;
    chk("t6_rst_tx_data", bus.tx_data, 0);
    chk("t6_rst_level", bus.level, 0);
    chk("t6_rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.tx_done_tick = 1'b1;
    step();
    bus.tx_done_tick = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (bus.tx_start !== 1'b0 || bus.busy !== 1'b0 || bus.level !== 5'd0) bad++;
    end
    chk("t6_stale_done_ignored", bad, 0);
    chk("t6_tx_data_after", bus.tx_data, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
